// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register.
//
// Captures the decoded control bundle, register-file read data, register
// specifiers, immediate and PC+4 on each rising edge of clk.
//   stallE  : hold every field. A held rd1E/rd2E is still refreshed when
//             writeback retires a value to the held source register.
//   flushE  : load an all-zero bubble. Flush wins over stall.
//   validD  : 0 marks a decode bubble. reg_writeE and mem_writeE are
//             forced low for that entry.
// On a normal load, a writeback to rsD/rtD in the same cycle is bypassed
// into rd1E/rd2E. Register 0 is never refreshed or bypassed.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   stallE, flushE              E-stage hold / bubble insert
//   validD, *D                  decode-stage bundle
//   reg_writeW, write_regW,
//   resultW                     writeback port, used for refresh/bypass
//   validE, *E                  registered execute-stage bundle
//
// Optional build macro ID_EX_BUBBLE_CNT_EN adds:
//   bubble_cnt_clr (in)  synchronous clear, wins over increment
//   bubble_cnt     (out) saturating count of bubbles entering E
module id_ex_reg #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int ACW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stallE,
  input  logic           flushE,
  input  logic           validD,
  input  logic           reg_writeD,
  input  logic           mem_to_regD,
  input  logic           mem_writeD,
  input  logic           alu_srcD,
  input  logic           reg_dstD,
  input  logic [ACW-1:0] alu_ctrlD,
  input  logic [DW-1:0]  rd1D,
  input  logic [DW-1:0]  rd2D,
  input  logic [AW-1:0]  rsD,
  input  logic [AW-1:0]  rtD,
  input  logic [AW-1:0]  rdD,
  input  logic [DW-1:0]  sign_immD,
  input  logic [DW-1:0]  pc_plus4D,
  input  logic           reg_writeW,
  input  logic [AW-1:0]  write_regW,
  input  logic [DW-1:0]  resultW,
`ifdef ID_EX_BUBBLE_CNT_EN
  input  logic           bubble_cnt_clr,
  output logic [31:0]    bubble_cnt,
`endif
  output logic           validE,
  output logic           reg_writeE,
  output logic           mem_to_regE,
  output logic           mem_writeE,
  output logic           alu_srcE,
  output logic           reg_dstE,
  output logic [ACW-1:0] alu_ctrlE,
  output logic [DW-1:0]  rd1E,
  output logic [DW-1:0]  rd2E,
  output logic [DW-1:0]  sign_immE,
  output logic [DW-1:0]  pc_plus4E,
  output logic [AW-1:0]  rsE,
  output logic [AW-1:0]  rtE,
  output logic [AW-1:0]  rdE
);

  logic wb_live;
  logic bypass_rs, bypass_rt;
  logic refresh_rs, refresh_rt;

  // A writeback to register 0 carries no architectural value.
  assign wb_live    = reg_writeW && (write_regW != '0);
  assign bypass_rs  = wb_live && (write_regW == rsD);
  assign bypass_rt  = wb_live && (write_regW == rtD);
  assign refresh_rs = wb_live && (write_regW == rsE);
  assign refresh_rt = wb_live && (write_regW == rtE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flushE) begin
      // Reset and flush both produce the all-zero bubble.
      validE      <= 1'b0;
      reg_writeE  <= 1'b0;
      mem_to_regE <= 1'b0;
      mem_writeE  <= 1'b0;
      alu_srcE    <= 1'b0;
      reg_dstE    <= 1'b0;
      alu_ctrlE   <= '0;
      rd1E        <= '0;
      rd2E        <= '0;
      sign_immE   <= '0;
      pc_plus4E   <= '0;
      rsE         <= '0;
      rtE         <= '0;
      rdE         <= '0;
    end else if (stallE) begin
      // Held operands must not go stale while the instruction waits.
      if (refresh_rs) rd1E <= resultW;
      if (refresh_rt) rd2E <= resultW;
    end else begin
      validE      <= validD;
      reg_writeE  <= reg_writeD && validD;
      mem_to_regE <= mem_to_regD;
      mem_writeE  <= mem_writeD && validD;
      alu_srcE    <= alu_srcD;
      reg_dstE    <= reg_dstD;
      alu_ctrlE   <= alu_ctrlD;
      rd1E        <= bypass_rs ? resultW : rd1D;
      rd2E        <= bypass_rt ? resultW : rd2D;
      sign_immE   <= sign_immD;
      pc_plus4E   <= pc_plus4D;
      rsE         <= rsD;
      rtE         <= rtD;
      rdE         <= rdD;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic bubble_in;

  assign bubble_in = flushE || (!stallE && !validD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble_cnt_clr) begin
      bubble_cnt <= '0;
    end else if (bubble_in && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
